// File: rtl/rename_map_table_pkg.sv
// Shared types for the rename stage: register index widths, checkpoint sizing
// and the packed map-table type.
package rename_map_table_pkg;

  localparam int PHYS_REG_BITS    = 6;
  localparam int ARCH_REGS        = 32;
  localparam int ARCH_REG_BITS    = 5;
  localparam int DEFAULT_NUM_CKPT = 4;

  typedef logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] map_table_t;

  // Architectural register i starts out in physical register i.
  function automatic map_table_t identity_map();
    map_table_t m;
    for (int i = 0; i < ARCH_REGS; i++) begin
      m[i] = PHYS_REG_BITS'(i);
    end
    return m;
  endfunction

endpackage

// File: rtl/rename_ckpt_ring.sv
// Branch checkpoint ring: per-slot map copy and free-list pointer, plus the
// head/tail/count bookkeeping for allocate, release and mispredict restore.
module rename_ckpt_ring
  import rename_map_table_pkg::*;
#(
  parameter int NUM_CKPT = DEFAULT_NUM_CKPT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      push_i,
  input  logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   push_map_i,
  input  logic [PHYS_REG_BITS-1:0]                  push_ptr_i,
  input  logic                                      release_i,
  input  logic                                      restore_i,
  input  logic [$clog2(NUM_CKPT)-1:0]               restore_id_i,
  output logic [$clog2(NUM_CKPT)-1:0]               tail_o,
  output logic                                      full_o,
  output logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0]   restore_map_o,
  output logic [PHYS_REG_BITS-1:0]                  restore_ptr_o
);

  localparam int CB = $clog2(NUM_CKPT);

  logic [CB-1:0]            head_q, head_d, tail_q, tail_d, restoreDist;
  logic [CB:0]              count_q, count_d;
  logic                     releaseOk;
  map_table_t               slotMap_q [NUM_CKPT];
  logic [PHYS_REG_BITS-1:0] slotPtr_q [NUM_CKPT];

  assign restoreDist   = restore_id_i - head_q;
  assign releaseOk     = release_i && (count_q != '0);
  assign tail_o        = tail_q;
  assign full_o        = (count_q == (CB+1)'(NUM_CKPT));
  assign restore_map_o = slotMap_q[restore_id_i];
  assign restore_ptr_o = slotPtr_q[restore_id_i];

  // Restore truncates the ring just past the named slot; a release in the same
  // cycle still retires the oldest entry on top of that.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (restore_i) begin
      tail_d  = restore_id_i + 1'b1;
      count_d = {1'b0, restoreDist} + 1'b1;
    end else if (push_i) begin
      tail_d  = tail_q + 1'b1;
      count_d = count_q + 1'b1;
    end
    if (releaseOk) begin
      head_d  = head_q + 1'b1;
      count_d = count_d - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      slotMap_q[tail_q] <= push_map_i;
      slotPtr_q[tail_q] <= push_ptr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && restore_i) begin
      assert ({1'b0, restoreDist} < count_q);
    end
  end

endmodule

// File: rtl/rename_map_table.sv
// Single-wide register rename with branch checkpoints feeding the free list.
// Define RENAME_OUT_REG_EN for a registered output stage; default is combinational.
module rename_map_table
  import rename_map_table_pkg::*;
#(
  parameter int NUM_CKPT = DEFAULT_NUM_CKPT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARCH_REG_BITS-1:0]      in_rs1,
  input  logic [ARCH_REG_BITS-1:0]      in_rs2,
  input  logic [ARCH_REG_BITS-1:0]      in_rd,
  input  logic                          in_rd_wen,
  input  logic                          in_is_branch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PHYS_REG_BITS-1:0]      out_prs1,
  output logic [PHYS_REG_BITS-1:0]      out_prs2,
  output logic [PHYS_REG_BITS-1:0]      out_prd,
  output logic [PHYS_REG_BITS-1:0]      out_old_prd,
  output logic [$clog2(NUM_CKPT)-1:0]   out_ckpt_id,
  input  logic [PHYS_REG_BITS-1:0]      fl_alloc_preg,
  input  logic                          fl_empty,
  output logic                          fl_alloc_en,
  input  logic [PHYS_REG_BITS-1:0]      fl_checkpoint_ptr,
  output logic                          fl_checkpoint_en,
  output logic                          fl_restore_en,
  output logic [PHYS_REG_BITS-1:0]      fl_restore_ptr,
  input  logic                          ckpt_release_en,
  input  logic                          restore_en,
  input  logic [$clog2(NUM_CKPT)-1:0]   restore_id
);

  localparam int CB = $clog2(NUM_CKPT);

  map_table_t               map_q, map_d, postMap, ringMap;
  logic [PHYS_REG_BITS-1:0] ringPtr, prs1, prs2, prd, oldPrd, ckptPtr;
  logic [CB-1:0]            ringTail, ckptId;
  logic                     ringFull, needsAlloc, slotFree, fire, pushCkpt;

  assign needsAlloc = in_rd_wen && (in_rd != '0);
  assign in_ready   = !restore_en && slotFree && !(needsAlloc && fl_empty)
                      && !(in_is_branch && ringFull);
  assign fire       = in_valid && in_ready;
  assign pushCkpt   = fire && in_is_branch;

  assign prs1    = map_q[in_rs1];
  assign prs2    = map_q[in_rs2];
  assign prd     = needsAlloc ? fl_alloc_preg : '0;
  assign oldPrd  = needsAlloc ? map_q[in_rd] : '0;
  assign ckptId  = in_is_branch ? ringTail : '0;
  // The checkpointed pointer must already account for this instruction's own allocation.
  assign ckptPtr = fl_checkpoint_ptr + PHYS_REG_BITS'(needsAlloc);

  assign fl_alloc_en      = fire && needsAlloc;
  assign fl_checkpoint_en = pushCkpt;
  assign fl_restore_en    = restore_en;
  assign fl_restore_ptr   = restore_en ? ringPtr : '0;

  always_comb begin
    postMap = map_q;
    if (fire && needsAlloc) begin
      postMap[in_rd] = fl_alloc_preg;
    end
  end

  always_comb begin
    map_d = postMap;
    if (restore_en) begin
      map_d = ringMap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= identity_map();
    end else begin
      map_q <= map_d;
    end
  end

  rename_ckpt_ring #(.NUM_CKPT(NUM_CKPT)) u_ring (
    .clk           (clk),
    .rst           (rst),
    .push_i        (pushCkpt),
    .push_map_i    (postMap),
    .push_ptr_i    (ckptPtr),
    .release_i     (ckpt_release_en),
    .restore_i     (restore_en),
    .restore_id_i  (restore_id),
    .tail_o        (ringTail),
    .full_o        (ringFull),
    .restore_map_o (ringMap),
    .restore_ptr_o (ringPtr)
  );

`ifdef RENAME_OUT_REG_EN
  logic                     outValid_q;
  logic [PHYS_REG_BITS-1:0] outPrs1_q, outPrs2_q, outPrd_q, outOldPrd_q;
  logic [CB-1:0]            outCkptId_q;

  assign slotFree = !outValid_q || out_ready;

  // Payload holds while dispatch stalls; a restore flushes whatever is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q  <= 1'b0;
      outPrs1_q   <= '0;
      outPrs2_q   <= '0;
      outPrd_q    <= '0;
      outOldPrd_q <= '0;
      outCkptId_q <= '0;
    end else if (restore_en) begin
      outValid_q  <= 1'b0;
    end else if (fire) begin
      outValid_q  <= 1'b1;
      outPrs1_q   <= prs1;
      outPrs2_q   <= prs2;
      outPrd_q    <= prd;
      outOldPrd_q <= oldPrd;
      outCkptId_q <= ckptId;
    end else if (out_ready) begin
      outValid_q  <= 1'b0;
    end
  end

  assign out_valid   = outValid_q;
  assign out_prs1    = outPrs1_q;
  assign out_prs2    = outPrs2_q;
  assign out_prd     = outPrd_q;
  assign out_old_prd = outOldPrd_q;
  assign out_ckpt_id = outCkptId_q;
`else
  assign slotFree    = out_ready;
  assign out_valid   = fire;
  assign out_prs1    = fire ? prs1 : '0;
  assign out_prs2    = fire ? prs2 : '0;
  assign out_prd     = fire ? prd : '0;
  assign out_old_prd = fire ? oldPrd : '0;
  assign out_ckpt_id = fire ? ckptId : '0;
`endif

endmodule

// File: tb/tb_rename_map_table.sv
// Self-checking bench for rename_map_table (default combinational-output build):
// directed scenarios followed by random traffic against a queue-based model.
module tb_rename_map_table;
  import rename_map_table_pkg::*;

  localparam int NCK = 4;

  typedef struct packed {
    logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] m;
    logic [PHYS_REG_BITS-1:0]                ptr;
  } ckpt_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [ARCH_REG_BITS-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic in_rd_wen = 1'b0, in_is_branch = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [PHYS_REG_BITS-1:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic [1:0] out_ckpt_id;
  logic [PHYS_REG_BITS-1:0] fl_alloc_preg = '0, fl_checkpoint_ptr = '0, fl_restore_ptr;
  logic fl_empty = 1'b0, fl_alloc_en, fl_checkpoint_en, fl_restore_en;
  logic ckpt_release_en = 1'b0, restore_en = 1'b0;
  logic [1:0] restore_id = '0;

  always #5 clk = ~clk;

  rename_map_table #(.NUM_CKPT(NCK)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_rs1            (in_rs1),
    .in_rs2            (in_rs2),
    .in_rd             (in_rd),
    .in_rd_wen         (in_rd_wen),
    .in_is_branch      (in_is_branch),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_prs1          (out_prs1),
    .out_prs2          (out_prs2),
    .out_prd           (out_prd),
    .out_old_prd       (out_old_prd),
    .out_ckpt_id       (out_ckpt_id),
    .fl_alloc_preg     (fl_alloc_preg),
    .fl_empty          (fl_empty),
    .fl_alloc_en       (fl_alloc_en),
    .fl_checkpoint_ptr (fl_checkpoint_ptr),
    .fl_checkpoint_en  (fl_checkpoint_en),
    .fl_restore_en     (fl_restore_en),
    .fl_restore_ptr    (fl_restore_ptr),
    .ckpt_release_en   (ckpt_release_en),
    .restore_en        (restore_en),
    .restore_id        (restore_id)
  );

  int total = 0;
  int bad = 0;

  // Reference model: architectural->physical map, queue of live checkpoints
  // (oldest first), id of the oldest, and the emulated free-list pointer.
  logic [ARCH_REGS-1:0][PHYS_REG_BITS-1:0] modelMap;
  ckpt_t ckptQ[$];
  int headId;
  int flPtr;

  logic [31:0] obsReady, obsPrs1, obsPrs2, obsPrd, obsOld, obsCkpt, obsAlloc, obsRestPtr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < ARCH_REGS; i++) modelMap[i] = PHYS_REG_BITS'(i);
    ckptQ.delete();
    headId = 0;
    flPtr  = 0;
  endtask

  task automatic applyStimulus(input int v, input int rs1, input int rs2, input int rd,
                               input int wen, input int br, input int rel, input int rest,
                               input int rid, input int ordy, input int empty);
    logic needs, expReady, expFire, relOk;
    logic [PHYS_REG_BITS-1:0] allocP;
    int k;
    ckpt_t c;
    @(negedge clk);
    allocP            = PHYS_REG_BITS'(32 + flPtr);
    in_valid          = (v != 0);
    in_rs1            = ARCH_REG_BITS'(rs1);
    in_rs2            = ARCH_REG_BITS'(rs2);
    in_rd             = ARCH_REG_BITS'(rd);
    in_rd_wen         = (wen != 0);
    in_is_branch      = (br != 0);
    ckpt_release_en   = (rel != 0);
    restore_en        = (rest != 0);
    restore_id        = 2'(rid);
    out_ready         = (ordy != 0);
    fl_empty          = (empty != 0);
    fl_alloc_preg     = allocP;
    fl_checkpoint_ptr = PHYS_REG_BITS'(flPtr);
    #2;
    needs    = (wen != 0) && (rd != 0);
    expReady = (rest == 0) && (ordy != 0) && !(needs && (empty != 0))
               && !((br != 0) && (ckptQ.size() == NCK));
    expFire  = (v != 0) && expReady;
    k        = (rid - headId + NCK) % NCK;
    checkOutput("in_ready", in_ready, expReady);
    checkOutput("out_valid", out_valid, expFire);
    checkOutput("fl_alloc_en", fl_alloc_en, expFire && needs);
    checkOutput("fl_checkpoint_en", fl_checkpoint_en, expFire && (br != 0));
    checkOutput("fl_restore_en", fl_restore_en, rest != 0);
    if (rest != 0) checkOutput("fl_restore_ptr", fl_restore_ptr, ckptQ[k].ptr);
    if (expFire) begin
      checkOutput("out_prs1", out_prs1, modelMap[rs1]);
      checkOutput("out_prs2", out_prs2, modelMap[rs2]);
      checkOutput("out_prd", out_prd, needs ? allocP : '0);
      checkOutput("out_old_prd", out_old_prd, needs ? modelMap[rd] : '0);
      checkOutput("out_ckpt_id", out_ckpt_id, (br != 0) ? (headId + ckptQ.size()) % NCK : 0);
    end
    obsReady = in_ready; obsPrs1 = out_prs1; obsPrs2 = out_prs2; obsPrd = out_prd;
    obsOld = out_old_prd; obsCkpt = out_ckpt_id; obsAlloc = fl_alloc_en;
    obsRestPtr = fl_restore_ptr;
    @(posedge clk);
    relOk = (rel != 0) && (ckptQ.size() != 0);
    if (rest != 0) begin
      modelMap = ckptQ[k].m;
      flPtr    = int'(ckptQ[k].ptr);
      while (ckptQ.size() > k + 1) void'(ckptQ.pop_back());
    end else if (expFire) begin
      if (needs) begin
        modelMap[rd] = allocP;
        flPtr = (flPtr + 1) % 64;
      end
      if (br != 0) begin
        c.m   = modelMap;
        c.ptr = PHYS_REG_BITS'(flPtr);
        ckptQ.push_back(c);
      end
    end
    if (relOk) begin
      void'(ckptQ.pop_front());
      headId = (headId + 1) % NCK;
    end
  endtask

  task automatic idleInputs();
    in_valid = 1'b0; in_rd_wen = 1'b0; in_is_branch = 1'b0;
    ckpt_release_en = 1'b0; restore_en = 1'b0; out_ready = 1'b1; fl_empty = 1'b0;
  endtask

  initial begin
    int v, rs1, rs2, rd, wen, br, rel, rest, rid, ordy, empty;
    modelReset();
    idleInputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #2;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_prd", out_prd, 0);
    checkOutput("rst_out_ckpt_id", out_ckpt_id, 0);
    checkOutput("rst_fl_alloc_en", fl_alloc_en, 0);
    checkOutput("rst_fl_restore_ptr", fl_restore_ptr, 0);

    // add x5,x1,x2 then add x5,x5,x0 then a write to x0
    applyStimulus(1, 1, 2, 5, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("add1_prs1", obsPrs1, 1);
    checkOutput("add1_prs2", obsPrs2, 2);
    checkOutput("add1_prd", obsPrd, 32);
    checkOutput("add1_old", obsOld, 5);
    checkOutput("add1_alloc", obsAlloc, 1);
    applyStimulus(1, 5, 0, 5, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("add2_prs1", obsPrs1, 32);
    checkOutput("add2_prd", obsPrd, 33);
    checkOutput("add2_old", obsOld, 32);
    applyStimulus(1, 3, 4, 0, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("x0_prd", obsPrd, 0);
    checkOutput("x0_alloc", obsAlloc, 0);

    // Free list empty: writer stalls, store proceeds
    applyStimulus(1, 1, 1, 7, 1, 0, 0, 0, 0, 1, 1);
    checkOutput("empty_writer_ready", obsReady, 0);
    applyStimulus(1, 5, 6, 7, 0, 0, 0, 0, 0, 1, 1);
    checkOutput("empty_store_ready", obsReady, 1);
    checkOutput("empty_store_prs1", obsPrs1, 33);

    // Checkpoint, two more renames, then restore to slot 0
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("br_ckpt_id", obsCkpt, 0);
    applyStimulus(1, 1, 1, 5, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("x5_p34", obsPrd, 34);
    applyStimulus(1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0);
    checkOutput("x6_p35", obsPrd, 35);
    applyStimulus(1, 5, 5, 5, 1, 0, 0, 1, 0, 1, 0);
    checkOutput("restore_ready", obsReady, 0);
    checkOutput("restore_ptr", obsRestPtr, 2);
    applyStimulus(1, 5, 6, 0, 0, 0, 0, 0, 0, 1, 0);
    checkOutput("post_restore_x5", obsPrs1, 33);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("post_restore_ckpt", obsCkpt, 1);

    // Reset in the middle of activity, then fill the ring
    @(negedge clk);
    rst = 1'b1;
    idleInputs();
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < NCK; i++) begin
      applyStimulus(1, i, i, 0, 0, 1, 0, 0, 0, 1, 0);
      checkOutput("fill_ckpt_id", obsCkpt, i);
    end
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("full_stall", obsReady, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
    checkOutput("full_release_stall", obsReady, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    checkOutput("after_release_ready", obsReady, 1);
    checkOutput("after_release_id", obsCkpt, 0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      v     = ($urandom_range(0, 3) != 0);
      rs1   = $urandom_range(0, 31);
      rs2   = $urandom_range(0, 31);
      rd    = $urandom_range(0, 31);
      wen   = ($urandom_range(0, 3) != 0);
      br    = ($urandom_range(0, 3) == 0);
      rel   = ($urandom_range(0, 5) == 0);
      rest  = (ckptQ.size() != 0) && ($urandom_range(0, 9) == 0);
      rid   = rest ? (headId + int'($urandom_range(0, ckptQ.size() - 1))) % NCK
                   : int'($urandom_range(0, 3));
      ordy  = ($urandom_range(0, 7) != 0);
      empty = ($urandom_range(0, 7) == 0);
      applyStimulus(v, rs1, rs2, rd, wen, br, rel, rest, rid, ordy, empty);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rename_map_table.md
# rename_map_table

- Single-wide register rename stage of the out-of-order core, sitting directly upstream of the free list and consuming its `alloc_preg`.
- Maps architectural sources and destinations to physical registers and records the displaced mapping for later release.
- Keeps a ring of branch checkpoints of the map table and the matching free-list pointer, and drives the free list's allocate, checkpoint and restore controls.
- Feeds the dispatch stage through a valid/ready handshake.

## Interface
- `NUM_CKPT`, 4: number of branch checkpoint slots; must be a power of two.
- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `in_valid` / `in_ready`, 1 each: upstream decode handshake; `in_valid` is an input, `in_ready` an output.
- `in_rs1`, `in_rs2`, `in_rd` input 5 each: architectural register indices.
- `in_rd_wen` input 1: the instruction writes `rd`.
- `in_is_branch` input 1: take a checkpoint when this instruction is renamed.
- `out_valid` output 1 / `out_ready` input 1: downstream dispatch handshake.
- `out_prs1`, `out_prs2`, `out_prd`, `out_old_prd` output PHYS_REG_BITS each: renamed operands.
- `out_ckpt_id` output $clog2(NUM_CKPT): checkpoint slot taken; 0 when none.
- `fl_alloc_preg` input PHYS_REG_BITS and `fl_empty` input 1: from the free list.
- `fl_alloc_en` output 1: allocate from the free list.
- `fl_checkpoint_ptr` input PHYS_REG_BITS and `fl_checkpoint_en` output 1: free-list checkpoint.
- `fl_restore_en` output 1 and `fl_restore_ptr` output PHYS_REG_BITS: free-list restore.
- `ckpt_release_en` input 1: oldest checkpoint's branch retired correctly.
- `restore_en` input 1, `restore_id` input $clog2(NUM_CKPT): mispredict recovery.

## Operation
- **Map table.** 32 entries × PHYS_REG_BITS. Reset value `map[i] = i` (p0–p31), consistent with the free list starting at p32.
- **Rename fires** when `in_valid && in_ready`.
  - `prs1 = map[rs1]`, `prs2 = map[rs2]`, read from the registered table.
- **Needs-alloc** = `in_rd_wen && in_rd != 0`.
  - When set: `fl_alloc_en = 1` in the fire cycle, `prd = fl_alloc_preg`, `old_prd = map[rd]`, and `map[rd] <= fl_alloc_preg` at the edge.
  - When clear: `prd = 0`, `old_prd = 0`, no allocation, `map` is unchanged.
- **`in_ready`** = `!restore_en` && output slot free && `!(needs-alloc && fl_empty)` && `!(in_is_branch && ckpt_count == NUM_CKPT)`.
  - An instruction without a destination is never blocked by `fl_empty`.
- **Checkpoint ring.** Head and tail indices plus `ckpt_count` (0..NUM_CKPT); each slot holds a map copy and a free-list pointer.
  - A branch fire writes slot `tail` with the post-update map, i.e. including its own `rd` mapping. For example, JAL x1 is captured with x1 pointing at the new register.
  - The same branch fire stores `fl_checkpoint_ptr`, plus 1 modulo 2^PHYS_REG_BITS if it allocated that cycle.
  - It then asserts `fl_checkpoint_en`, sets `out_ckpt_id = tail`, increments `tail`, and increments `ckpt_count`.
  - `ckpt_release_en`: `head++`, `ckpt_count--`. Release while `ckpt_count == 0` is ignored.
- **Restore** (`restore_en`):
  - At the edge: `map <= slot[restore_id].map`; `fl_restore_en = 1` combinationally; `fl_restore_ptr = slot[restore_id].ptr`.
  - Ring update: `tail <= restore_id+1`, `ckpt_count <= ((restore_id − head) mod NUM_CKPT) + 1`.
  - The output register is flushed (`out_valid <= 0`) and no rename fires that cycle.
- **Simultaneous events.**
  - Release and restore in the same cycle: both apply, `head++` and `ckpt_count` is the restore value minus 1.
  - Release and branch fire in the same cycle: net `ckpt_count` unchanged.
- **`restore_id` validity.** `restore_id` must name a live slot; otherwise behaviour is undefined (flagged by a simulation assertion).

## Timing
- **Reset values.** `out_valid = 0`, all `out_*` = 0, `fl_*_en = 0`, head = tail = 0, `ckpt_count = 0`, map = identity. Reset asserted mid-operation discards every in-flight instruction and checkpoint.
- **Latency.** With the output register: 1 cycle from fire to `out_valid`. Without it: 0 cycles (see Configuration).
- **Holding.** Outputs hold stable while `out_valid && !out_ready`.
- **Map visibility.** A map update is visible to the next cycle's rename; no same-cycle bypass is needed at single width.
- **Recovery.** Renaming resumes the cycle after `restore_en` deasserts.

## Configuration
- **`RENAME_OUT_REG_EN` defined:** registered output stage.
  - "Output slot free" = `!out_valid || out_ready`.
  - `out_*` update at the fire edge.
- **`RENAME_OUT_REG_EN` undefined:** outputs are combinational from the fire cycle.
  - `out_valid = in_valid && in_ready`.
  - "Output slot free" = `out_ready`.
  - The flush on restore is implicit.

## Structure
- **`ooo_types` additions:** PHYS_REG_BITS (existing), `ARCH_REGS = 32`, `ARCH_REG_BITS = 5`, `NUM_CKPT`, and a `map_table_t` typedef (array of 32 preg indices).
- **Sub-module:** one natural candidate, `rename_ckpt_ring`, holding the slot storage and head/tail/count logic.

## Test plan
- **Reset:** release reset → `out_valid = 0`; rename `add x5,x1,x2` → `prs1 = 1`, `prs2 = 2`, `prd = 32`, `old_prd = 5`, `fl_alloc_en` high for 1 cycle.
- **Chain:** `add x5,x5,x0` next → `prs1 = 32`, `prd = 33`, `old_prd = 32`. Then `rd = x0` → `prd = 0` and no `fl_alloc_en`.
- **Free list empty:** `fl_empty = 1` → a `rd`-writing instruction stalls (`in_ready = 0`) while a store (`in_rd_wen = 0`) fires.
- **Checkpoint and restore:** branch renamed (`out_ckpt_id = 0`), then x5 → p34, x6 → p35; `restore_en`, `restore_id = 0` → `fl_restore_en` with the saved ptr, next rename of x5 reads p33, `ckpt_count = 1`.
- **Ring full:** 4 branches outstanding → 5th branch stalls; `ckpt_release_en` → it fires next cycle with `out_ckpt_id = 0`.
- **Backpressure** (`RENAME_OUT_REG_EN`): `out_ready = 0` for 3 cycles → outputs held, `in_ready = 0`, no map change.
